// File: rtl/down_counter_reload.sv
// down_counter_reload: WIDTH-bit down counter that counts a reload value to
// zero, then stops (one-shot) or reloads (periodic), with a one-cycle tc.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   load, load_val      capture load_val into reload and count, go IDLE
//   start               IDLE/DONE: copy reload into count, enter RUN
//   en                  count enable while in RUN
//   periodic            1 = auto-reload at zero, 0 = stop in DONE
//   count               current count
//   tc                  registered terminal-count pulse
//   busy, done          state is RUN / state is DONE
//
// Optional (define DOWNCNT_STICKY_EN):
//   clr_flag            clears tc_flag
//   tc_flag             sticky copy of tc; set wins over clear
module down_counter_reload #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             en,
    input  logic             periodic,
`ifdef DOWNCNT_STICKY_EN
    input  logic             clr_flag,
    output logic             tc_flag,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Per-bit decrement: a bit flips while every lower bit is zero.
    logic [WIDTH-1:0] dec;
    logic [WIDTH:0]   borrow;
    logic             is_zero;

    always_comb begin
        borrow[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            dec[i]        = count_q[i] ^ borrow[i];
            borrow[i + 1] = borrow[i] & ~count_q[i];
        end
        is_zero = borrow[WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            // load wins over everything in RUN, including a zero cycle
            reload_d = load_val;
            count_d  = load_val;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        count_d = reload_q;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        if (is_zero) begin
                            tc_d = 1'b1;
                            if (periodic) begin
                                count_d = reload_q;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            count_d = dec;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef DOWNCNT_STICKY_EN
    logic tc_flag_q, tc_flag_d;

    always_comb begin
        tc_flag_d = tc_flag_q;
        if (clr_flag) tc_flag_d = 1'b0;
        if (tc_d)     tc_flag_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) tc_flag_q <= 1'b0;
        else     tc_flag_q <= tc_flag_d;
    end

    assign tc_flag = tc_flag_q;
`endif

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_down_counter_reload.sv
// Testbench for down_counter_reload (WIDTH=3).
// Each scenario queues stimulus rows; expectations go to a scoreboard.
module tb_down_counter_reload;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_val = '0;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic       periodic = 1'b0;
    logic       clr_flag = 1'b0;
    logic [2:0] count;
    logic       tc, busy, done;
    logic       tc_flag;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       rst, load, start, en, periodic, clr;
        logic [2:0] lv;
        logic [2:0] c;
        logic       tc, b, d, fl;
    } row_t;

    row_t sq[$];
    row_t sb[$];

    always #5 clk = ~clk;

    down_counter_reload #(.WIDTH(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .en       (en),
        .periodic (periodic),
`ifdef DOWNCNT_STICKY_EN
        .clr_flag (clr_flag),
        .tc_flag  (tc_flag),
`endif
        .count    (count),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

`ifndef DOWNCNT_STICKY_EN
    assign tc_flag = 1'b0;
`endif

    task automatic add(input logic r, l, s, e, p, cl,
                       input logic [2:0] lv, c,
                       input logic t, b, d, fl);
        row_t x;
        x.rst = r; x.load = l; x.start = s; x.en = e;
        x.periodic = p; x.clr = cl; x.lv = lv; x.c = c;
        x.tc = t; x.b = b; x.d = d; x.fl = fl;
        sq.push_back(x);
    endtask

    task automatic drive(input row_t x);
        rst = x.rst; load = x.load; start = x.start; en = x.en;
        periodic = x.periodic; clr_flag = x.clr; load_val = x.lv;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t e;
        for (int i = 0; i < 2; i++) begin
            rst = 1'b1;
            load = 1'($urandom); start = 1'($urandom);
            en = 1'($urandom); periodic = 1'($urandom);
            load_val = 3'($urandom);
            e = '{default: '0};
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total++;
            if ({count, tc, busy, done} !== {e.c, e.tc, e.b, e.d}) begin
                bad++;
                $display("FAIL reset%0d got c=%0d tc=%b b=%b d=%b want c=%0d tc=%b b=%b d=%b",
                         i, count, tc, busy, done, e.c, e.tc, e.b, e.d);
            end
        end
        rst = 1'b0; load = 0; start = 0; en = 0; periodic = 0;
    endtask

    task automatic test_oneshot();
        row_t s, e;
        int i = 0;
        add(0,1,0,0,0,0, 3'd5, 3'd5, 0,0,0,0);
        add(0,0,1,0,0,0, 3'd0, 3'd5, 0,1,0,0);
        for (int k = 4; k >= 0; k--)
            add(0,0,0,1,0,0, 3'd0, 3'(k), 0,1,0,0);
        add(0,0,0,1,0,0, 3'd0, 3'd0, 1,0,1,0);
        add(0,0,0,1,0,0, 3'd0, 3'd0, 0,0,1,0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            drive(s);
            e = sb.pop_front();
            total++;
            if ({count, tc, busy, done} !== {e.c, e.tc, e.b, e.d}) begin
                bad++;
                $display("FAIL oneshot%0d got c=%0d tc=%b b=%b d=%b want c=%0d tc=%b b=%b d=%b",
                         i, count, tc, busy, done, e.c, e.tc, e.b, e.d);
            end
            i++;
        end
    endtask

    task automatic test_periodic();
        row_t s, e;
        int i = 0;
        add(0,1,0,0,1,0, 3'd2, 3'd2, 0,0,0,0);
        add(0,0,1,0,1,0, 3'd0, 3'd2, 0,1,0,0);
        // reload=2: period of 3 edges, tc on the edge that reloads
        for (int k = 1; k <= 12; k++)
            add(0,0,0,1,1,0, 3'd0, 3'((300 + 2 - k) % 3),
                1'(k % 3 == 0), 1,0,0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            drive(s);
            e = sb.pop_front();
            total++;
            if ({count, tc, busy, done} !== {e.c, e.tc, e.b, e.d}) begin
                bad++;
                $display("FAIL periodic%0d got c=%0d tc=%b b=%b d=%b want c=%0d tc=%b b=%b d=%b",
                         i, count, tc, busy, done, e.c, e.tc, e.b, e.d);
            end
            i++;
        end
    endtask

    task automatic test_en_gate();
        row_t s, e;
        int i = 0;
        add(0,1,0,0,0,0, 3'd7, 3'd7, 0,0,0,0);
        add(0,0,1,0,0,0, 3'd0, 3'd7, 0,1,0,0);
        add(0,0,0,1,0,0, 3'd0, 3'd6, 0,1,0,0);
        add(0,0,0,0,0,0, 3'd0, 3'd6, 0,1,0,0);
        add(0,0,0,1,0,0, 3'd0, 3'd5, 0,1,0,0);
        add(0,0,0,0,0,0, 3'd0, 3'd5, 0,1,0,0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            drive(s);
            e = sb.pop_front();
            total++;
            if ({count, tc, busy, done} !== {e.c, e.tc, e.b, e.d}) begin
                bad++;
                $display("FAIL en_gate%0d got c=%0d tc=%b b=%b d=%b want c=%0d tc=%b b=%b d=%b",
                         i, count, tc, busy, done, e.c, e.tc, e.b, e.d);
            end
            i++;
        end
    endtask

    task automatic test_load_override();
        row_t s, e;
        int i = 0;
        add(0,1,0,0,0,0, 3'd1, 3'd1, 0,0,0,0);
        add(0,0,1,0,0,0, 3'd0, 3'd1, 0,1,0,0);
        // start while in RUN is ignored
        add(0,0,1,1,0,0, 3'd0, 3'd0, 0,1,0,0);
        // load at the zero cycle suppresses tc
        add(0,1,0,1,0,0, 3'd4, 3'd4, 0,0,0,0);
        add(0,0,0,1,0,0, 3'd0, 3'd4, 0,0,0,0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            drive(s);
            e = sb.pop_front();
            total++;
            if ({count, tc, busy, done} !== {e.c, e.tc, e.b, e.d}) begin
                bad++;
                $display("FAIL load_ovr%0d got c=%0d tc=%b b=%b d=%b want c=%0d tc=%b b=%b d=%b",
                         i, count, tc, busy, done, e.c, e.tc, e.b, e.d);
            end
            i++;
        end
    endtask

    task automatic test_rst_mid();
        row_t s, e;
        int i = 0;
        add(0,0,1,0,0,0, 3'd0, 3'd4, 0,1,0,0);
        add(0,0,0,1,0,0, 3'd0, 3'd3, 0,1,0,0);
        add(1,0,0,1,0,0, 3'd0, 3'd0, 0,0,0,0);
        add(0,0,0,1,0,0, 3'd0, 3'd0, 0,0,0,0);
        // reload register was cleared by reset
        add(0,0,1,1,0,0, 3'd0, 3'd0, 0,1,0,0);
        add(0,0,0,1,0,0, 3'd0, 3'd0, 1,0,1,0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            drive(s);
            e = sb.pop_front();
            total++;
            if ({count, tc, busy, done} !== {e.c, e.tc, e.b, e.d}) begin
                bad++;
                $display("FAIL rst_mid%0d got c=%0d tc=%b b=%b d=%b want c=%0d tc=%b b=%b d=%b",
                         i, count, tc, busy, done, e.c, e.tc, e.b, e.d);
            end
            i++;
        end
    endtask

    task automatic test_reload_zero();
        row_t s, e;
        int i = 0;
        add(0,0,1,0,1,0, 3'd0, 3'd0, 0,1,0,0);
        add(0,0,0,1,1,0, 3'd0, 3'd0, 1,1,0,0);
        add(0,0,0,1,1,0, 3'd0, 3'd0, 1,1,0,0);
        add(0,0,0,0,1,0, 3'd0, 3'd0, 0,1,0,0);
        add(0,0,0,1,0,0, 3'd0, 3'd0, 1,0,1,0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            drive(s);
            e = sb.pop_front();
            total++;
            if ({count, tc, busy, done} !== {e.c, e.tc, e.b, e.d}) begin
                bad++;
                $display("FAIL reload0_%0d got c=%0d tc=%b b=%b d=%b want c=%0d tc=%b b=%b d=%b",
                         i, count, tc, busy, done, e.c, e.tc, e.b, e.d);
            end
            i++;
        end
    endtask

`ifdef DOWNCNT_STICKY_EN
    task automatic test_sticky();
        row_t s, e;
        int i = 0;
        add(0,0,0,0,0,1, 3'd0, 3'd0, 0,0,1,0);
        add(0,1,0,0,0,0, 3'd1, 3'd1, 0,0,0,0);
        add(0,0,1,0,0,0, 3'd0, 3'd1, 0,1,0,0);
        add(0,0,0,1,0,0, 3'd0, 3'd0, 0,1,0,0);
        add(0,0,0,1,0,0, 3'd0, 3'd0, 1,0,1,1);
        add(0,0,0,0,0,0, 3'd0, 3'd0, 0,0,1,1);
        add(0,0,0,0,0,0, 3'd0, 3'd0, 0,0,1,1);
        add(0,0,0,0,0,1, 3'd0, 3'd0, 0,0,1,0);
        add(0,0,1,0,0,0, 3'd0, 3'd1, 0,1,0,0);
        add(0,0,0,1,0,0, 3'd0, 3'd0, 0,1,0,0);
        // set and clear on the same edge: set wins
        add(0,0,0,1,0,1, 3'd0, 3'd0, 1,0,1,1);
        add(0,0,0,0,0,0, 3'd0, 3'd0, 0,0,1,1);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            drive(s);
            e = sb.pop_front();
            total++;
            if ({count, tc, busy, done, tc_flag} !==
                {e.c, e.tc, e.b, e.d, e.fl}) begin
                bad++;
                $display("FAIL sticky%0d got c=%0d tc=%b b=%b d=%b fl=%b want c=%0d tc=%b b=%b d=%b fl=%b",
                         i, count, tc, busy, done, tc_flag,
                         e.c, e.tc, e.b, e.d, e.fl);
            end
            i++;
        end
    endtask
`endif

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_oneshot();
        test_periodic();
        test_en_gate();
        test_load_override();
        test_rst_mid();
        test_reload_zero();
`ifdef DOWNCNT_STICKY_EN
        test_sticky();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/down_counter_reload.md
Name: down_counter_reload

Overview:
- Programmable WIDTH-bit down counter, the count-down counterpart of the team's 3-bit up counter.
- Holds a reload value and counts from it to zero, then either stops (one-shot) or reloads (periodic).
- Emits a one-cycle terminal-count pulse; used as a timer/tick divider next to the up counter in the counter library.
- Next-state logic is written as explicit per-bit equations driving synchronous-reset flops.

Parameters:
- WIDTH, 3, counter and reload width in bits (legal range 2..16).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- load  input  1  capture load_val into the reload register and into count; return to IDLE.
- load_val  input  WIDTH  value captured on load.
- start  input  1  in IDLE or DONE: copy the reload register into count and enter RUN.
- en  input  1  count enable; in RUN, decrement only when en=1.
- periodic  input  1  1 = auto-reload at zero, 0 = one-shot; sampled at the zero cycle.
- count  output  WIDTH  current count value.
- tc  output  1  registered terminal-count pulse, high for exactly one cycle.
- busy  output  1  high while state is RUN.
- done  output  1  high while state is DONE (one-shot finished).

Behaviour:
- Reset (rst=1 at a clock edge): count=0, reload register=0, state=IDLE, tc=0, busy=0, done=0. Reset overrides all other inputs.
- Priority per edge: rst > load > start > decrement.
- States: IDLE, RUN, DONE. busy and done are decoded from the registered state, so they carry no combinational path from the inputs.
- IDLE:
  - load=1: reload<=load_val, count<=load_val; stay in IDLE.
  - start=1: count<=reload; go to RUN.
  - otherwise: hold.
- RUN, en=0: count holds, tc=0.
- RUN, en=1, count!=0: count<=count-1. The result is never below zero; the subtraction is modulo 2^WIDTH but the wrap is unreachable.
- RUN, en=1, count==0:
  - tc=1 on the next cycle.
  - periodic=1: count<=reload, stay in RUN.
  - periodic=0: count stays 0, go to DONE.
- DONE:
  - start=1: count<=reload; go to RUN.
  - load=1: capture load_val as in IDLE; go to IDLE.
  - otherwise: hold, with done=1.
- load in RUN: capture load_val into reload and count, go to IDLE, and suppress tc even when count==0 and en=1 in the same cycle.
- start while already in RUN: ignored.
- reload==0 on start: enter RUN with count=0; the first enabled cycle produces tc.
- Period with periodic=1 and en held high: reload+1 cycles between tc pulses.
- tc is never high for two consecutive cycles, except periodic with reload==0, where tc is high every enabled cycle.
- Reset mid-RUN: the next cycle shows the reset values; no tc is produced.

Optional Feature:
- Macro: DOWNCNT_STICKY_EN.
- Defined:
  - Adds input clr_flag (1 bit) and output tc_flag (1 bit).
  - tc_flag is set on the same edge that raises tc, is cleared by clr_flag=1, and resets to 0.
  - If set and clear coincide, set wins.
- Undefined: neither port exists and the remaining behaviour is unchanged.

Test Plan:
- Reset for 2 cycles with random inputs -> count=0, tc=0, busy=0, done=0 the cycle after reset.
- WIDTH=3, load_val=5, then start, en=1, periodic=0 -> count 5,4,3,2,1,0; tc high exactly one cycle after the 0 cycle; state DONE with done=1 and count=0.
- load_val=2, periodic=1, en=1 for 12 cycles -> count 2,1,0,2,1,0,...; tc every 3 cycles; busy stays 1.
- load_val=7, run with en toggling 1,0,1,0 -> count decrements only on en=1 cycles (7,6,6,5,5); no tc until zero.
- In RUN at count=0 with en=1, assert load with load_val=4 -> next cycle count=4, state IDLE, tc=0. Separately, assert rst at count=3 -> next cycle count=0, busy=0, no tc.
- DOWNCNT_STICKY_EN defined: run to tc -> tc_flag=1 and stays set; clr_flag pulse -> 0; clr_flag asserted in the same cycle tc is set -> tc_flag=1.
